// File: rtl/regintfc_responder.sv
// Register-interface target with a bank of read/write control registers, a read-only status word,
// a fixed number of response wait cycles and error responses for illegal accesses.

package regintfc_pkg;

   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        valid;
   } reg_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        error;
      logic        ready;
   } reg_rsp_t;

endpackage

module regintfc_responder
   import regintfc_pkg::*;
#(
   parameter int unsigned NUM_REGS  = 4,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned LATENCY   = 1,
   parameter logic [31:0] RESET_VAL = 32'h0
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  reg_req_t                 reg_req_i,
   output reg_rsp_t                 reg_rsp_o,
   input  logic [31:0]              status_i,
   output logic [NUM_REGS*32-1:0]   regs_o,
   output logic [NUM_REGS-1:0]      reg_wr_o
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StWait = 2'd1;
   localparam logic [1:0] StResp = 2'd2;

   // WAIT lasts LATENCY-1 cycles; the counter holds the number of WAIT cycles still to go.
   localparam int unsigned WaitLoad = (LATENCY > 1) ? LATENCY - 2 : 0;

   logic [1:0]                 state_q, state_d;
   logic [3:0]                 cnt_q, cnt_d;
   logic [NUM_REGS-1:0][31:0]  regs_q, regs_d;
   logic [NUM_REGS-1:0]        wr_q, wr_d;
   logic [31:0]                rdata_q, rdata_d;
   logic                       error_q, error_d;

   logic        accept;
   logic [31:0] addr_diff;
   logic [29:0] off;
   logic        in_range;
   logic        is_status;
   logic        legal;
   logic [31:0] rd_val;

   // BASE_ADDR is word aligned, so the low bits of the difference equal the low address bits.
   assign accept    = (state_q == StIdle) && reg_req_i.valid;
   assign addr_diff = reg_req_i.addr - BASE_ADDR;
   assign off       = addr_diff[31:2];
   assign in_range  = (reg_req_i.addr >= BASE_ADDR) && (off <= 30'(NUM_REGS));
   assign is_status = (off == 30'(NUM_REGS));
   assign legal     = (addr_diff[1:0] == 2'b00) && in_range &&
                      !(reg_req_i.write && is_status);

   always_comb begin
      rd_val = '0;
      if (is_status) begin
         rd_val = status_i;
      end
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (off == 30'(i)) begin
            rd_val = regs_q[i];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         StIdle: begin
            if (reg_req_i.valid) begin
               if (LATENCY == 1) begin
                  state_d = StResp;
               end else begin
                  state_d = StWait;
                  cnt_d   = 4'(WaitLoad);
               end
            end
         end
         StWait: begin
            if (cnt_q == 4'd0) begin
               state_d = StResp;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Everything about the transaction is resolved at acceptance; later request changes are ignored.
   always_comb begin
      regs_d  = regs_q;
      wr_d    = '0;
      rdata_d = rdata_q;
      error_d = error_q;
      if (accept) begin
         rdata_d = '0;
         error_d = !legal;
         if (legal && !reg_req_i.write) begin
            rdata_d = rd_val;
         end
         if (legal && reg_req_i.write) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
               if (off == 30'(i)) begin
                  wr_d[i] = 1'b1;
                  for (int unsigned b = 0; b < 4; b++) begin
                     if (reg_req_i.wstrb[b]) begin
                        regs_d[i][8*b +: 8] = reg_req_i.wdata[8*b +: 8];
                     end
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         regs_q  <= {NUM_REGS{RESET_VAL}};
         wr_q    <= '0;
         rdata_q <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         regs_q  <= regs_d;
         wr_q    <= wr_d;
         rdata_q <= rdata_d;
         error_q <= error_d;
      end
   end

   always_comb begin
      reg_rsp_o       = '0;
      reg_rsp_o.ready = (state_q == StResp);
      if (state_q == StResp) begin
         reg_rsp_o.rdata = rdata_q;
         reg_rsp_o.error = error_q;
      end
   end

   assign regs_o   = regs_q;
   assign reg_wr_o = wr_q;

endmodule

// File: tb/tb_regintfc_responder.sv
// Randomized scoreboard bench for regintfc_responder against a transaction-level register model.

module tb_regintfc_responder;
   import regintfc_pkg::*;

   localparam int unsigned NR   = 4;
   localparam logic [31:0] BASE = 32'h0000_0040;
   localparam int unsigned LAT  = 3;
   localparam logic [31:0] RVAL = 32'h0;

   typedef struct {
      int          due;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   reg_req_t           req = '0;
   reg_rsp_t           rsp;
   logic [31:0]        status = '0;
   logic [NR*32-1:0]   regs;
   logic [NR-1:0]      wr;

   int cyc = 0;
   int n_chk = 0;
   int n_pass = 0;
   int last_due = -10;
   int wr_cyc = -1;
   logic [NR-1:0] wr_mask = '0;
   logic [31:0] model [NR];
   exp_t q[$];

   regintfc_responder #(
      .NUM_REGS  (NR),
      .BASE_ADDR (BASE),
      .LATENCY   (LAT),
      .RESET_VAL (RVAL)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .reg_req_i (req),
      .reg_rsp_o (rsp),
      .status_i  (status),
      .regs_o    (regs),
      .reg_wr_o  (wr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input bit ok, input logic [127:0] act,
                        input logic [127:0] expv);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, expv);
   endtask

   // Monitor: every cycle the response, register image and write pulses must match the model.
   exp_t             e_m;
   logic [33:0]      rsp_want, rsp_got;
   logic [NR*32-1:0] regs_want;
   logic [NR-1:0]    wr_want;
   always @(negedge clk) begin
      rsp_want = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
         e_m = q.pop_front();
         rsp_want = {e_m.rdata, e_m.err, 1'b1};
      end
      rsp_got = {rsp.rdata, rsp.error, rsp.ready};
      check("rsp", rsp_got == rsp_want, 128'(rsp_got), 128'(rsp_want));
      for (int i = 0; i < NR; i++) regs_want[32*i +: 32] = model[i];
      check("regs", regs == regs_want, 128'(regs), 128'(regs_want));
      wr_want = (cyc == wr_cyc) ? wr_mask : '0;
      check("reg_wr", wr == wr_want, 128'(wr), 128'(wr_want));
   end

   // Drive one request; returns just after its acceptance edge with valid still high.
   task automatic issue(input logic [31:0] a, input bit w, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] st);
      int          acc;
      exp_t        e;
      logic [31:0] diff, offv;
      bit          legal;
      req.addr  = a;
      req.write = w;
      req.wdata = d;
      req.wstrb = s;
      req.valid = 1'b1;
      status    = st;
      acc = (cyc + 1 > last_due + 2) ? cyc + 1 : last_due + 2;
      do begin
         @(posedge clk);
         #1;
      end while (cyc < acc);
      diff  = a - BASE;
      offv  = diff >> 2;
      legal = (a[1:0] == 2'b00) && (a >= BASE) && (offv <= NR) && !(w && offv == NR);
      e.due   = acc + LAT - 1;
      e.err   = !legal;
      e.rdata = '0;
      if (legal && !w) e.rdata = (offv == NR) ? st : model[offv];
      if (legal && w) begin
         for (int b = 0; b < 4; b++) if (s[b]) model[offv][8*b +: 8] = d[8*b +: 8];
         wr_cyc  = acc;
         wr_mask = '0;
         wr_mask[offv[1:0]] = 1'b1;
      end
      q.push_back(e);
      last_due = e.due;
      status = $urandom;
   endtask

   task automatic drop();
      req.valid = 1'b0;
   endtask

   task automatic wait_done();
      while (cyc <= last_due + 1) @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      #2;
      rst = 1'b1;
      req.valid = 1'b0;
      q.delete();
      for (int i = 0; i < NR; i++) model[i] = RVAL;
      wr_cyc = -1;
      repeat (n) @(negedge clk);
      #2;
      rst = 1'b0;
      last_due = -10;
   endtask

   initial begin
      logic [31:0] a;
      for (int i = 0; i < NR; i++) model[i] = RVAL;
      @(negedge clk);
      do_reset(2);

      issue(BASE + 32'h8, 1'b0, 32'h0, 4'h0, 32'h0);
      drop(); wait_done();
      issue(BASE + 32'h4, 1'b1, 32'hDEAD_BEEF, 4'b0011, 32'h0);
      drop(); wait_done();
      issue(BASE + 32'h4, 1'b1, 32'h1234_5678, 4'b1111, 32'h0);
      drop(); wait_done();
      issue(BASE + 32'h4, 1'b0, 32'h0, 4'h0, 32'h0);
      drop(); wait_done();
      issue(BASE + 32'h0, 1'b1, 32'hA5A5_A5A5, 4'b1111, 32'h0);
      drop(); wait_done();
      issue(BASE + 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
      drop(); wait_done();

      issue(BASE + 32'h14, 1'b0, 32'h0, 4'h0, 32'h0);
      drop(); wait_done();
      issue(BASE + 32'h2, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0);
      drop(); wait_done();
      issue(BASE + 32'h10, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0);
      drop(); wait_done();
      issue(BASE + 32'h10, 1'b0, 32'h0, 4'h0, 32'hCAFE_0001);
      drop(); wait_done();
      issue(BASE - 32'h4, 1'b0, 32'h0, 4'h0, 32'h0);
      drop(); wait_done();

      // Back-to-back with valid held high; fields change while the first is in flight.
      issue(BASE + 32'h0, 1'b1, 32'h1, 4'hF, 32'h0);
      issue(BASE + 32'h4, 1'b1, 32'h2, 4'hF, 32'h0);
      drop(); wait_done();

      // Reset while a read is waiting: no response, registers back to reset value.
      issue(BASE + 32'h8, 1'b1, 32'h5555_AAAA, 4'hF, 32'h0);
      drop(); wait_done();
      issue(BASE + 32'h8, 1'b0, 32'h0, 4'h0, 32'h0);
      drop();
      @(negedge clk);
      do_reset(3);
      issue(BASE + 32'h8, 1'b0, 32'h0, 4'h0, 32'h0);
      drop(); wait_done();

      for (int n = 0; n < 200; n++) begin
         a = BASE - 32'h8 + 32'(4 * $urandom_range(0, 8));
         if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
         if ($urandom_range(0, 15) == 0) a = $urandom;
         issue(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), $urandom);
         if ($urandom_range(0, 2) != 0) begin
            drop();
            if ($urandom_range(0, 1) == 1) wait_done();
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
      end
      drop(); wait_done();
      repeat (2) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
